piso_tx: RTL and testbench
==========================

// Module: piso_tx
// PURPOSE
//   Parallel-in serial-out transmitter: takes a WIDTH-bit word via valid/ready handshake and
//   drives it one bit per shift tick on serial_out. Transmit counterpart of the serial-in
//   shift-register receiver: MSB-first output loops back to an identical word in the receiver.
//   Sits between a word-producing block and a 1-bit serial link; shift_en acts as bit-rate tick.
// PARAMETERS
//   WIDTH       4   word width in bits; legal range >= 2
//   MSB_FIRST   1   1: bit WIDTH-1 sent first; 0: bit 0 sent first
//   IDLE_LEVEL  0   serial_out level whenever no data bit is being driven
// PORTS
//   clk           in   1      clock; all state updates on rising edge
//   reset         in   1      synchronous, active-high reset
//   shift_en      in   1      bit tick; current bit is consumed on a cycle with shift_en=1
//   par_data      in   WIDTH  word to transmit; sampled only on handshake
//   par_valid     in   1      producer has a word on par_data
//   par_ready     out  1      block accepts a word this cycle (combinational, see below)
//   serial_out    out  1      serial data bit (registered)
//   serial_valid  out  1      serial_out carries a data bit (registered)
//   frame_last    out  1      serial_out carries the last bit of the word (registered)
//   busy          out  1      word in flight; equals serial_valid
// BEHAVIOUR
//   - Reset (sampled at clk edge): state=IDLE, bit_cnt=0, shift reg=0, serial_out=IDLE_LEVEL,
//     serial_valid=0, frame_last=0, busy=0. Reset mid-word aborts the word; no partial resume.
//   - States: IDLE, SHIFT. Handshake = par_valid & par_ready.
//   - par_ready = (state==IDLE) | (state==SHIFT & frame_last & shift_en). Does not depend on par_valid.
//   - IDLE: serial_out=IDLE_LEVEL, serial_valid=0. On handshake: capture par_data, bit_cnt=0,
//     -> SHIFT. Latency: first data bit on serial_out the cycle after the handshake.
//   - SHIFT: serial_out = current bit, held until a cycle with shift_en=1; then bit_cnt+1 and
//     next bit driven the following cycle. shift_en=0 freezes all state (bit stretched).
//   - frame_last=1 iff SHIFT and bit_cnt==WIDTH-1.
//   - Last bit consumed (frame_last & shift_en): with handshake -> reload, bit_cnt=0, stay SHIFT
//     (back-to-back, zero gap); without -> IDLE, serial_out=IDLE_LEVEL next cycle.
//   - par_valid while SHIFT and not (frame_last & shift_en): ignored, par_ready=0, no capture.
//   - par_data changes after handshake have no effect on the word in flight.
//   - bit_cnt width $clog2(WIDTH); never exceeds WIDTH-1; no wrap beyond reload.
//   - MSB_FIRST=1: shift left, output reg[WIDTH-1]; MSB_FIRST=0: shift right, output reg[0].
//   - shift_en tied high: exactly one bit per clk, WIDTH clks per word.
// STRUCTURE
//   - Shared package piso_pkg: typedef enum logic {PISO_IDLE, PISO_SHIFT} piso_state_t;
//     localparam-free helper for counter width via $clog2(WIDTH) at module level.
//   - Single module: state reg, WIDTH-bit shift reg, bit counter, registered outputs.
//     No sub-module warranted; combinational par_ready kept in this module.
// TESTING  (WIDTH=4, MSB_FIRST=1, IDLE_LEVEL=0 unless stated)
//   1 Load 4'b1011, shift_en=1 -> serial_out 1,0,1,1 on cycles 1..4 after handshake,
//     frame_last only on cycle 4; loopback into serial receiver yields 4'b1011.
//   2 Back-to-back 4'b1100 then 4'b0011, par_valid held -> 8 contiguous bits 1,1,0,0,0,0,1,1,
//     serial_valid never drops, second handshake on frame_last cycle.
//   3 Load 4'b1001, shift_en pattern 1,0,0,1,1,1 -> bit1 (0) held 3 cycles; frame_last on 4th tick.
//   4 Reset asserted after 2 bits of 4'b1110 -> next cycle serial_out=0, serial_valid=0,
//     busy=0, par_ready=1; next word 4'b0101 sent intact.
//   5 par_valid with 4'b1111 pulsed mid-word of 4'b0000 -> par_ready=0, ignored; 0,0,0,0 sent.
//   6 MSB_FIRST=0, IDLE_LEVEL=1, load 4'b0001 -> line 1 idle, then 1,0,0,0, then idle 1.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types for the parallel-in serial-out transmitter.
package piso_pkg;

    // Transmitter control states: waiting for a word, or shifting one out.
    typedef enum logic {
        PISO_IDLE  = 1'b0,
        PISO_SHIFT = 1'b1
    } piso_state_t;

endpackage : piso_pkg

// File: rtl/piso_tx_if.sv
// Word-side handshake plus serial-side outputs of the transmitter.
// The producer drives through "master"; the transmitter connects through "slave".
interface piso_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] par_data;
    logic             par_valid;
    logic             par_ready;
    logic             serial_out;
    logic             serial_valid;
    logic             frame_last;
    logic             busy;

    modport master (
        output par_data,
        output par_valid,
        input  par_ready,
        input  serial_out,
        input  serial_valid,
        input  frame_last,
        input  busy
    );

    modport slave (
        input  par_data,
        input  par_valid,
        output par_ready,
        output serial_out,
        output serial_valid,
        output frame_last,
        output busy
    );
endinterface : piso_tx_if

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter. Accepts a WIDTH-bit word on a valid/ready
// handshake and emits it one bit per shift_en tick. The last bit's tick can
// accept the next word, so back-to-back words leave no idle gap on the line.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     shift_en,
    piso_tx_if.slave bus
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             serial_out_q, serial_out_d;
    logic             serial_valid_q, serial_valid_d;
    logic             frame_last_q, frame_last_d;

    logic             last_tick_s;
    logic             par_ready_s;
    logic             handshake_s;

    // Handshake decode: ready when idle or when the last bit is consumed this cycle.
    always_comb begin
        last_tick_s = (state_q == PISO_SHIFT) && frame_last_q && shift_en;
        par_ready_s = (state_q == PISO_IDLE) || last_tick_s;
        handshake_s = bus.par_valid && par_ready_s;
    end

    // Next-state, shift register, bit counter and next registered outputs.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            PISO_IDLE: begin
                if (handshake_s) begin
                    shreg_d   = bus.par_data;
                    bit_cnt_d = '0;
                    state_d   = PISO_SHIFT;
                end else begin
                    state_d   = PISO_IDLE;
                end
            end
            PISO_SHIFT: begin
                if (!shift_en) begin
                    // Bit is stretched: hold everything.
                    state_d = PISO_SHIFT;
                end else if (frame_last_q) begin
                    if (handshake_s) begin
                        shreg_d   = bus.par_data;
                        bit_cnt_d = '0;
                        state_d   = PISO_SHIFT;
                    end else begin
                        shreg_d   = '0;
                        bit_cnt_d = '0;
                        state_d   = PISO_IDLE;
                    end
                end else begin
                    if (MSB_FIRST) begin
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    end else begin
                        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                    end
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = PISO_IDLE;
                shreg_d   = '0;
                bit_cnt_d = '0;
            end
        endcase

        serial_valid_d = (state_d == PISO_SHIFT);
        frame_last_d   = serial_valid_d && (bit_cnt_d == CNT_LAST);
        if (serial_valid_d) begin
            serial_out_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
        end else begin
            serial_out_d = IDLE_LEVEL;
        end
    end

    // State and output registers with synchronous reset; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= PISO_IDLE;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            serial_out_q   <= IDLE_LEVEL;
            serial_valid_q <= 1'b0;
            frame_last_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            frame_last_q   <= frame_last_d;
        end
    end

    assign bus.par_ready    = par_ready_s;
    assign bus.serial_out   = serial_out_q;
    assign bus.serial_valid = serial_valid_q;
    assign bus.frame_last   = frame_last_q;
    assign bus.busy         = serial_valid_q;

endmodule : piso_tx

// File: tb/tb_piso_tx.sv
// Directed testbench for piso_tx. Inputs are driven and registered outputs are
// sampled on the falling clock edge; the DUT updates on the rising edge.
module tb_piso_tx;

    logic clk;
    logic reset;
    logic shift_en;

    int n_checks = 0;
    int n_fail   = 0;

    piso_tx_if #(.WIDTH(4)) b1 ();
    piso_tx_if #(.WIDTH(4)) b6 ();

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .bus      (b1.slave)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_lsb (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .bus      (b6.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset       = 1'b1;
        shift_en    = 1'b0;
        b1.par_valid = 1'b0;
        b1.par_data  = 4'b0000;
        b6.par_valid = 1'b0;
        b6.par_data  = 4'b0000;
        repeat (2) @(negedge clk);
        n_checks++;
        if (b1.serial_out !== 1'b0 || b1.serial_valid !== 1'b0 || b1.frame_last !== 1'b0 || b1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got out=%b valid=%b last=%b busy=%b, expected 0 0 0 0",
                     b1.serial_out, b1.serial_valid, b1.frame_last, b1.busy);
        end
        n_checks++;
        if (b1.par_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", b1.par_ready);
        end
        n_checks++;
        if (b6.serial_out !== 1'b1 || b6.serial_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_high: got out=%b valid=%b, expected 1 0", b6.serial_out, b6.serial_valid);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [3:0] exp_bits = 4'b1011;
        logic [3:0] rx = 4'b0000;
        b1.par_data  = 4'b1011;
        b1.par_valid = 1'b1;
        shift_en     = 1'b1;
        #1;
        n_checks++;
        if (b1.par_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_ready_idle: got %b expected 1", b1.par_ready);
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            b1.par_valid = 1'b0;
            b1.par_data  = 4'b0110;
            n_checks++;
            if (b1.serial_out !== exp_bits[4-i] || b1.serial_valid !== 1'b1 ||
                b1.frame_last !== (i == 4) || b1.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL t1_bit%0d: got out=%b valid=%b last=%b busy=%b, expected out=%b valid=1 last=%b busy=1",
                         i, b1.serial_out, b1.serial_valid, b1.frame_last, b1.busy, exp_bits[4-i], (i == 4));
            end
            if (b1.serial_valid === 1'b1) rx = {rx[2:0], b1.serial_out};
        end
        #1;
        n_checks++;
        if (b1.par_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_ready_last: got %b expected 1", b1.par_ready);
        end
        @(negedge clk);
        n_checks++;
        if (b1.serial_out !== 1'b0 || b1.serial_valid !== 1'b0 || b1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_idle_after: got out=%b valid=%b busy=%b, expected 0 0 0",
                     b1.serial_out, b1.serial_valid, b1.busy);
        end
        n_checks++;
        if (rx !== 4'b1011) begin
            n_fail++;
            $display("FAIL t1_loopback: got %b expected 1011", rx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_bits = 8'b11000011;
        b1.par_data  = 4'b1100;
        b1.par_valid = 1'b1;
        shift_en     = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (b1.serial_out !== exp_bits[8-i] || b1.serial_valid !== 1'b1 ||
                b1.frame_last !== (i == 4 || i == 8)) begin
                n_fail++;
                $display("FAIL t2_bit%0d: got out=%b valid=%b last=%b, expected out=%b valid=1 last=%b",
                         i, b1.serial_out, b1.serial_valid, b1.frame_last, exp_bits[8-i], (i == 4 || i == 8));
            end
            if (i == 1) b1.par_data = 4'b0011;
            if (i == 3 || i == 4) begin
                #1;
                n_checks++;
                if (b1.par_ready !== (i == 4)) begin
                    n_fail++;
                    $display("FAIL t2_ready_c%0d: got %b expected %b", i, b1.par_ready, (i == 4));
                end
            end
            if (i == 5) b1.par_valid = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (b1.serial_valid !== 1'b0 || b1.serial_out !== 1'b0) begin
            n_fail++;
            $display("FAIL t2_idle_after: got out=%b valid=%b, expected 0 0", b1.serial_out, b1.serial_valid);
        end
    endtask

    task automatic test_stretch();
        logic [5:0] exp_out  = 6'b100001;
        logic [5:0] exp_last = 6'b000001;
        logic [5:0] pat      = 6'b100111;
        b1.par_data  = 4'b1001;
        b1.par_valid = 1'b1;
        shift_en     = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            b1.par_valid = 1'b0;
            n_checks++;
            if (b1.serial_out !== exp_out[6-i] || b1.serial_valid !== 1'b1 || b1.frame_last !== exp_last[6-i]) begin
                n_fail++;
                $display("FAIL t3_cyc%0d: got out=%b valid=%b last=%b, expected out=%b valid=1 last=%b",
                         i, b1.serial_out, b1.serial_valid, b1.frame_last, exp_out[6-i], exp_last[6-i]);
            end
            shift_en = pat[6-i];
        end
        @(negedge clk);
        n_checks++;
        if (b1.serial_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_idle_after: got valid=%b expected 0", b1.serial_valid);
        end
    endtask

    task automatic test_reset_midword();
        logic [3:0] exp_bits = 4'b0101;
        b1.par_data  = 4'b1110;
        b1.par_valid = 1'b1;
        shift_en     = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            b1.par_valid = 1'b0;
            n_checks++;
            if (b1.serial_out !== 1'b1 || b1.serial_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL t4_bit%0d: got out=%b valid=%b, expected 1 1", i, b1.serial_out, b1.serial_valid);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (b1.serial_out !== 1'b0 || b1.serial_valid !== 1'b0 || b1.busy !== 1'b0 || b1.frame_last !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_after_reset: got out=%b valid=%b busy=%b last=%b, expected 0 0 0 0",
                     b1.serial_out, b1.serial_valid, b1.busy, b1.frame_last);
        end
        reset        = 1'b0;
        b1.par_data  = 4'b0101;
        b1.par_valid = 1'b1;
        #1;
        n_checks++;
        if (b1.par_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_ready: got %b expected 1", b1.par_ready);
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            b1.par_valid = 1'b0;
            n_checks++;
            if (b1.serial_out !== exp_bits[4-i] || b1.serial_valid !== 1'b1 || b1.frame_last !== (i == 4)) begin
                n_fail++;
                $display("FAIL t4_new_bit%0d: got out=%b valid=%b last=%b, expected out=%b valid=1 last=%b",
                         i, b1.serial_out, b1.serial_valid, b1.frame_last, exp_bits[4-i], (i == 4));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_midword();
        b1.par_data  = 4'b0000;
        b1.par_valid = 1'b1;
        shift_en     = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            b1.par_valid = 1'b0;
            n_checks++;
            if (b1.serial_out !== 1'b0 || b1.serial_valid !== 1'b1 || b1.frame_last !== (i == 4)) begin
                n_fail++;
                $display("FAIL t5_bit%0d: got out=%b valid=%b last=%b, expected out=0 valid=1 last=%b",
                         i, b1.serial_out, b1.serial_valid, b1.frame_last, (i == 4));
            end
            if (i == 2) begin
                b1.par_data  = 4'b1111;
                b1.par_valid = 1'b1;
                #1;
                n_checks++;
                if (b1.par_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL t5_ready_midword: got %b expected 0", b1.par_ready);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (b1.serial_valid !== 1'b0 || b1.serial_out !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_no_capture: got out=%b valid=%b, expected 0 0", b1.serial_out, b1.serial_valid);
        end
    endtask

    task automatic test_lsb_first();
        logic [3:0] exp_bits = 4'b1000;
        n_checks++;
        if (b6.serial_out !== 1'b1 || b6.serial_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_idle_before: got out=%b valid=%b, expected 1 0", b6.serial_out, b6.serial_valid);
        end
        b6.par_data  = 4'b0001;
        b6.par_valid = 1'b1;
        shift_en     = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            b6.par_valid = 1'b0;
            n_checks++;
            if (b6.serial_out !== exp_bits[4-i] || b6.serial_valid !== 1'b1 || b6.frame_last !== (i == 4)) begin
                n_fail++;
                $display("FAIL t6_bit%0d: got out=%b valid=%b last=%b, expected out=%b valid=1 last=%b",
                         i, b6.serial_out, b6.serial_valid, b6.frame_last, exp_bits[4-i], (i == 4));
            end
        end
        @(negedge clk);
        n_checks++;
        if (b6.serial_out !== 1'b1 || b6.serial_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_idle_after: got out=%b valid=%b, expected 1 0", b6.serial_out, b6.serial_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stretch();
        test_reset_midword();
        test_ignore_midword();
        test_lsb_first();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_piso_tx
